// File: rtl/jfpjc_jpeg_pkg.sv
// Shared JPEG-path definitions: default datapath widths, the zigzag scan
// table (zigzag position -> row-major natural index) and the quantizer FSM
// state encoding.
package jfpjc_jpeg_pkg;

  localparam int COEF_W_DEFAULT  = 16;
  localparam int RECIP_W_DEFAULT = 17;
  localparam int OUT_W_DEFAULT   = 12;

  // Entry k is the row-major index of the k-th coefficient in JPEG zigzag order.
  localparam logic [5:0] ZIGZAG_TO_NATURAL [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } zq_state_e;

endpackage

// File: rtl/zigzag_lut.sv
// Combinational zigzag position -> natural (row-major) index lookup.
//   k_i       : zigzag position 0..63
//   natural_o : row-major index of that coefficient in the 8x8 block
module zigzag_lut
  import jfpjc_jpeg_pkg::*;
(
  input  logic [5:0] k_i,
  output logic [5:0] natural_o
);

  assign natural_o = ZIGZAG_TO_NATURAL[k_i];

endmodule

// File: rtl/zigzag_quantizer_88.sv
// Reads an 8x8 DCT block in zigzag order from a synchronous coefficient RAM,
// multiplies each coefficient by a quantization reciprocal read in parallel,
// rounds half away from zero, saturates and streams 64 results out.
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   start                  : one-cycle pulse, accepted only in IDLE
//   coef_read_addr/_data   : coefficient RAM port (1-cycle read latency)
//   qtable_read_addr/_data : reciprocal RAM port (same address, same latency)
//   out_valid/out_ready    : output handshake; out_index/out_coef payload
//   busy, finished         : block in progress / one-cycle completion pulse
module zigzag_quantizer_88
  import jfpjc_jpeg_pkg::*;
#(
  parameter int COEF_W  = COEF_W_DEFAULT,
  parameter int RECIP_W = RECIP_W_DEFAULT,
  parameter int OUT_W   = OUT_W_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic [5:0]                coef_read_addr,
  input  logic signed [COEF_W-1:0]  coef_read_data,
  output logic [5:0]                qtable_read_addr,
  input  logic [RECIP_W-1:0]        qtable_read_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [5:0]                out_index,
  output logic signed [OUT_W-1:0]   out_coef,
  output logic                      busy,
  output logic                      finished
);

  localparam int PROD_W = COEF_W + RECIP_W;
  localparam logic [PROD_W-1:0] HALF_LSB  = PROD_W'(32768);
  localparam logic [PROD_W-1:0] POS_LIMIT = PROD_W'((1 << (OUT_W - 1)) - 1);
  localparam logic [PROD_W-1:0] NEG_LIMIT = PROD_W'(1 << (OUT_W - 1));
  localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic [OUT_W-1:0]  OUT_MIN   = OUT_W'(1 << (OUT_W - 1));

  zq_state_e state_q;
  logic [5:0] k_q, addr_q, s0_index_q, s1_index_q, s2_index_q, out_index_q;
  logic s0_valid_q, s1_valid_q, s2_valid_q, out_valid_q;
  logic busy_q, finished_q, s2_neg_q, hold_valid_q;
  logic [PROD_W-1:0] s2_prod_q;
  logic signed [COEF_W-1:0] coef_hold_q;
  logic [RECIP_W-1:0] recip_hold_q;
  logic signed [OUT_W-1:0] out_coef_q;

  logic [5:0] natural_d;
  logic stall, out_fire;
  logic signed [COEF_W-1:0] coef_eff;
  logic [RECIP_W-1:0] recip_eff;
  logic [COEF_W:0] coef_ext, coef_mag;
  logic [PROD_W-1:0] prod_d, rnd_full;
  logic signed [OUT_W-1:0] sat_d;

  zigzag_lut u_lut (
    .k_i       (k_q),
    .natural_o (natural_d)
  );

  // A full output register that is not taken freezes the whole pipeline.
  assign stall    = out_valid_q & ~out_ready;
  assign out_fire = out_valid_q & out_ready;

  // Multiply stage input: |coef| (17 bits so -32768 maps to 32768) times reciprocal.
  always_comb begin
    coef_eff  = hold_valid_q ? coef_hold_q : coef_read_data;
    recip_eff = hold_valid_q ? recip_hold_q : qtable_read_data;
    coef_ext  = {coef_eff[COEF_W-1], coef_eff};
    if (coef_eff[COEF_W-1]) begin
      coef_mag = ~coef_ext + (COEF_W + 1)'(1);
    end else begin
      coef_mag = coef_ext;
    end
    prod_d = PROD_W'(coef_mag) * PROD_W'(recip_eff);
  end

  // Round the magnitude, then apply the sign with saturation to the output range.
  always_comb begin
    rnd_full = (s2_prod_q + HALF_LSB) >> 16;
    if (s2_neg_q) begin
      if (rnd_full >= NEG_LIMIT) begin
        sat_d = OUT_MIN;
      end else begin
        sat_d = OUT_W'(PROD_W'(0) - rnd_full);
      end
    end else begin
      if (rnd_full > POS_LIMIT) begin
        sat_d = OUT_MAX;
      end else begin
        sat_d = OUT_W'(rnd_full);
      end
    end
  end

  // Control FSM: zigzag counter, address register (S0), busy/finished.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      k_q        <= 6'd0;
      addr_q     <= 6'd0;
      s0_index_q <= 6'd0;
      s0_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      finished_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            k_q     <= 6'd0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            addr_q     <= natural_d;
            s0_index_q <= k_q;
            s0_valid_q <= 1'b1;
            k_q        <= k_q + 6'd1;
            if (k_q == 6'd63) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!stall) begin
            s0_valid_q <= 1'b0;
          end
          if (out_fire && (out_index_q == 6'd63)) begin
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The RAMs keep re-reading the held S0 address during a stall, so the S1
  // item's data is captured on the first stalled edge and used until release.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      coef_hold_q  <= '0;
      recip_hold_q <= '0;
    end else if (stall && !hold_valid_q) begin
      hold_valid_q <= 1'b1;
      coef_hold_q  <= coef_read_data;
      recip_hold_q <= qtable_read_data;
    end else if (!stall) begin
      hold_valid_q <= 1'b0;
    end
  end

  // Pipeline stages S1 (RAM return), S2 (product) and S3 (output register).
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_index_q  <= 6'd0;
      s2_valid_q  <= 1'b0;
      s2_index_q  <= 6'd0;
      s2_neg_q    <= 1'b0;
      s2_prod_q   <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= 6'd0;
      out_coef_q  <= '0;
    end else if (!stall) begin
      s1_valid_q  <= s0_valid_q;
      s1_index_q  <= s0_index_q;
      s2_valid_q  <= s1_valid_q;
      s2_index_q  <= s1_index_q;
      s2_neg_q    <= coef_eff[COEF_W-1];
      s2_prod_q   <= prod_d;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_index_q <= s2_index_q;
        out_coef_q  <= sat_d;
      end
    end
  end

  assign coef_read_addr   = addr_q;
  assign qtable_read_addr = addr_q;
  assign out_valid        = out_valid_q;
  assign out_index        = out_index_q;
  assign out_coef         = out_coef_q;
  assign busy             = busy_q;
  assign finished         = finished_q;

endmodule

// File: tb/tb_zigzag_quantizer_88.sv
module tb_zigzag_quantizer_88;

  logic clock, reset, start, out_ready, out_valid, busy, finished;
  logic [5:0] coef_read_addr, qtable_read_addr, out_index;
  logic signed [15:0] coef_read_data;
  logic [16:0] qtable_read_data;
  logic signed [11:0] out_coef;

  int tests = 0;
  int fails = 0;
  int ready_mode = 0;
  int exp_count = 0;
  int coef_mem [64];
  int recip_mem [64];
  int expected [64];
  int zz [64];
  bit prev_stall = 1'b0;
  int prev_coef, prev_index;

  zigzag_quantizer_88 dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .coef_read_addr   (coef_read_addr),
    .coef_read_data   (coef_read_data),
    .qtable_read_addr (qtable_read_addr),
    .qtable_read_data (qtable_read_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_index        (out_index),
    .out_coef         (out_coef),
    .busy             (busy),
    .finished         (finished)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous-read RAM models for the coefficient buffer and reciprocal table.
  always @(posedge clock) begin
    coef_read_data   <= 16'(coef_mem[coef_read_addr]);
    qtable_read_data <= 17'(recip_mem[qtable_read_addr]);
  end

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference quantizer: round half away from zero, then saturate.
  function automatic int quant(input int c, input int r);
    longint m, q;
    m = (c < 0) ? -longint'(c) : longint'(c);
    q = (m * longint'(r) + 64'sd32768) / 64'sd65536;
    if (c < 0) q = -q;
    if (q > 2047) q = 2047;
    if (q < -2048) q = -2048;
    return int'(q);
  endfunction

  // Zigzag order built by walking the anti-diagonals of the 8x8 block.
  task automatic build_zigzag();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
      end
    end
  endtask

  task automatic compute_expected();
    for (int i = 0; i < 64; i++) expected[i] = quant(coef_mem[zz[i]], recip_mem[zz[i]]);
  endtask

  function automatic int rand_recip();
    int q = int'($urandom_range(1, 255));
    return (65536 + q / 2) / q;
  endfunction

  function automatic int rand_coef();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Ready generator: 0 = always ready, 1 = toggling, 2 = random.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: every presented output against the model sequence.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_coef_held", out_coef, prev_coef);
        check("stall_index_held", out_index, prev_index);
      end
      if (out_valid) begin
        if (exp_count > 63) begin
          check("extra_output_count", exp_count, 63);
        end else begin
          check("out_index", out_index, exp_count);
          check("out_coef", out_coef, expected[exp_count]);
          if (out_ready) exp_count++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_coef  = int'(out_coef);
      prev_index = int'(out_index);
    end
  end

  task automatic run_block(input int mode, input bit inject, input string tag);
    int t = 0, first_t = -1, fin_t = -1, stalls = 0;
    bit injected = 1'b0;
    ready_mode = mode;
    exp_count  = 0;
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(negedge clock);
    check({tag, "/busy_after_start"}, busy, 1);
    while (t < 400 && fin_t < 0) begin
      if (out_valid && !out_ready) stalls++;
      if (inject && !injected && out_valid && out_index == 6'd10) begin
        start = 1'b1;
        injected = 1'b1;
      end
      @(posedge clock); t++; #1; start = 1'b0;
      @(negedge clock);
      if (out_valid && first_t < 0) first_t = t;
      if (finished) fin_t = t;
    end
    if (fin_t < 0) begin
      check({tag, "/finished_timeout"}, t, -1);
    end else begin
      check({tag, "/first_valid_cycle"}, first_t, 4);
      check({tag, "/finished_cycle"}, fin_t, 68 + stalls);
      check({tag, "/output_count"}, exp_count, 64);
      check({tag, "/busy_at_finish"}, busy, 0);
    end
    if (inject) begin
      repeat (6) begin
        @(negedge clock);
        check({tag, "/quiet_finished"}, finished, 0);
        check({tag, "/quiet_valid"}, out_valid, 0);
        check({tag, "/quiet_busy"}, busy, 0);
      end
    end
  endtask

  int pin_order [6] = '{0, 1, 8, 16, 9, 2};
  int rnd_coef [6]  = '{100, 24, -24, -23, 8, 7};
  int rnd_exp [6]   = '{6, 2, -2, -1, 1, 0};
  int sat_coef [5]  = '{32767, -32768, 2047, -2049, 2048};
  int sat_exp [5]   = '{2047, -2048, 2047, -2048, 2047};

  initial begin
    reset = 1'b1;
    start = 1'b0;
    build_zigzag();
    for (int i = 0; i < 64; i++) begin coef_mem[i] = 0; recip_mem[i] = 65536; end
    compute_expected();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_coef_addr", coef_read_addr, 0);
    check("rst_qtable_addr", qtable_read_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_coef", out_coef, 0);
    check("rst_busy", busy, 0);
    check("rst_finished", finished, 0);
    @(posedge clock); #1; reset = 1'b0;

    // Order: coefficient equals its natural index, unity reciprocal.
    for (int i = 0; i < 64; i++) begin coef_mem[i] = i; recip_mem[i] = 65536; end
    compute_expected();
    for (int i = 0; i < 6; i++) check("model_order_pin", expected[i], pin_order[i]);
    check("model_order_last", expected[63], 63);
    run_block(0, 1'b0, "order");

    // Rounding with Q=16, started right after the previous finished pulse.
    for (int i = 0; i < 64; i++) begin coef_mem[zz[i]] = i * 37 - 1000; recip_mem[i] = 4096; end
    for (int i = 0; i < 6; i++) coef_mem[zz[i]] = rnd_coef[i];
    compute_expected();
    for (int i = 0; i < 6; i++) check("model_round_pin", expected[i], rnd_exp[i]);
    run_block(0, 1'b0, "round");

    // Saturation plus random fill, toggling ready.
    for (int i = 0; i < 64; i++) begin coef_mem[i] = rand_coef(); recip_mem[i] = rand_recip(); end
    for (int i = 0; i < 5; i++) begin coef_mem[zz[i]] = sat_coef[i]; recip_mem[zz[i]] = 65536; end
    compute_expected();
    for (int i = 0; i < 5; i++) check("model_sat_pin", expected[i], sat_exp[i]);
    run_block(1, 1'b0, "toggle");

    // Random data with random backpressure.
    for (int i = 0; i < 64; i++) begin coef_mem[i] = rand_coef(); recip_mem[i] = rand_recip(); end
    compute_expected();
    run_block(2, 1'b0, "random");

    // Start pulse while busy must be ignored.
    run_block(0, 1'b1, "start_busy");

    // Reset at the handshake of index 20, then a fresh block.
    begin
      int w = 0;
      ready_mode = 0;
      exp_count  = 0;
      @(posedge clock); #1; start = 1'b1;
      @(posedge clock); #1; start = 1'b0;
      while (w < 200 && !(out_valid && out_index == 6'd20)) begin
        @(posedge clock); #1; w++;
      end
      check("rst_mid_reach_idx20", out_index, 20);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("rst_mid_out_valid", out_valid, 0);
      check("rst_mid_busy", busy, 0);
      @(posedge clock); #1; reset = 1'b0;
    end
    for (int i = 0; i < 64; i++) begin coef_mem[i] = rand_coef(); recip_mem[i] = rand_recip(); end
    compute_expected();
    run_block(0, 1'b0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
